// File: rtl/stage_sequencer_pkg.sv
// stage_sequencer_pkg: shared stage codes, RV32I opcode constants and decode helpers
// for the multi-cycle stage sequencer.
//   stage_e                 - 3-bit stage bus encoding (REGISTER_UPDATE must stay 4)
//   RISCV_*                 - major opcodes the sequencer needs to steer on
//   FUNCT12_EBREAK          - instr[31:20] value that marks EBREAK under RISCV_SYSTEM
package stage_sequencer_pkg;

    typedef enum logic [2:0] {
        STAGE_FETCH           = 3'd0,
        STAGE_DECODE          = 3'd1,
        STAGE_EXECUTE         = 3'd2,
        STAGE_MEM             = 3'd3,
        STAGE_REGISTER_UPDATE = 3'd4,
        STAGE_HALT            = 3'd7
    } stage_e;

    localparam logic [6:0] RISCV_LOAD   = 7'b0000011;
    localparam logic [6:0] RISCV_STORE  = 7'b0100011;
    localparam logic [6:0] RISCV_BRANCH = 7'b1100011;
    localparam logic [6:0] RISCV_SYSTEM = 7'b1110011;

    localparam logic [11:0] FUNCT12_EBREAK = 12'h001;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == RISCV_LOAD) || (op == RISCV_STORE);
    endfunction

    function automatic logic is_ebreak(input logic [6:0] op, input logic [11:0] f12);
        return (op == RISCV_SYSTEM) && (f12 == FUNCT12_EBREAK);
    endfunction

    // Stores and branches have no destination register.
    function automatic logic writes_rd(input logic [6:0] op);
        return (op != RISCV_STORE) && (op != RISCV_BRANCH);
    endfunction

endpackage

// File: rtl/stage_sequencer_wait_timer.sv
// stage_wait_timer: counts consecutive stalled memory-wait cycles and flags expiry.
//   clk       - core clock
//   rst_n     - asynchronous active-low reset
//   wait_i    - high in a FETCH/MEM cycle whose ack has not arrived
//   expired_o - high in the stalled cycle that completes MEM_TIMEOUT waits
//               (never high when MEM_TIMEOUT is 0)
module stage_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wait_i,
    output logic expired_o
);

    localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of earlier stalled cycles, so the current stalled
    // cycle is wait number cnt_q+1; expiry fires when that reaches MEM_TIMEOUT.
    // Any cycle that is not a stall (ack, or not waiting at all) clears it, which
    // covers every state change out of FETCH or MEM.
    assign expired_o = (MEM_TIMEOUT != 0) && wait_i && (cnt_q == LAST);
    assign cnt_d     = (wait_i && !expired_o) ? cnt_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle RV32I instruction stage controller.
// Optional performance counters are built when STAGE_SEQ_PERF_EN is defined.
//   clk, rst_n      - core clock, asynchronous active-low reset
//   opcode, funct12 - fields of the latched instruction
//   imem_ack        - instruction fetch data valid
//   dmem_ack        - data load/store complete
//   halt_req        - external halt request, honoured only in REGISTER_UPDATE
//   resume          - one-cycle pulse that leaves HALT
//   stage           - current stage code
//   imem_req, dmem_req, ir_en, pc_en, rd_we - requests/strobes decoded from stage
//   halted          - core is in HALT
//   bus_error       - sticky memory-timeout flag
//   cycle_cnt, instret_cnt (STAGE_SEQ_PERF_EN only) - non-halted cycles, retired instructions
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [11:0] funct12,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        halt_req,
    input  logic        resume,
    output logic [2:0]  stage,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        ir_en,
    output logic        pc_en,
    output logic        rd_we,
    output logic        halted,
    output logic        bus_error
`ifdef STAGE_SEQ_PERF_EN
    ,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
`endif
);

    stage_e state_q, state_d;
    logic   bus_error_q, bus_error_d;
    logic   mem_wait, timeout;

    assign mem_wait = ((state_q == STAGE_FETCH) && !imem_ack) ||
                      ((state_q == STAGE_MEM)   && !dmem_ack);

    stage_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .wait_i    (mem_wait),
        .expired_o (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= STAGE_FETCH;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Timeout only fires on a stalled cycle, so an ack in the same cycle always
    // takes the normal path and never sets bus_error.
    always_comb begin
        state_d     = state_q;
        bus_error_d = bus_error_q | timeout;
        case (state_q)
            STAGE_FETCH:           state_d = imem_ack ? STAGE_DECODE :
                                             timeout  ? STAGE_HALT   : STAGE_FETCH;
            STAGE_DECODE:          state_d = STAGE_EXECUTE;
            STAGE_EXECUTE:         state_d = is_mem_op(opcode)          ? STAGE_MEM  :
                                             is_ebreak(opcode, funct12) ? STAGE_HALT :
                                                                          STAGE_REGISTER_UPDATE;
            STAGE_MEM:             state_d = dmem_ack ? STAGE_REGISTER_UPDATE :
                                             timeout  ? STAGE_HALT : STAGE_MEM;
            STAGE_REGISTER_UPDATE: state_d = halt_req ? STAGE_HALT : STAGE_FETCH;
            STAGE_HALT:            state_d = resume ? STAGE_FETCH : STAGE_HALT;
            // Codes 5 and 6 are not valid stages; recover through FETCH.
            default:               state_d = STAGE_FETCH;
        endcase
    end

    // Strobes are decoded straight from the state register so an asynchronous
    // reset withdraws any outstanding memory request without waiting for a clock.
    always_comb begin
        stage     = state_q;
        imem_req  = (state_q == STAGE_FETCH);
        ir_en     = (state_q == STAGE_FETCH) && imem_ack;
        dmem_req  = (state_q == STAGE_MEM);
        pc_en     = (state_q == STAGE_REGISTER_UPDATE);
        rd_we     = (state_q == STAGE_REGISTER_UPDATE) && writes_rd(opcode);
        halted    = (state_q == STAGE_HALT);
        bus_error = bus_error_q;
    end

`ifdef STAGE_SEQ_PERF_EN
    logic [63:0] cycle_q, instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != STAGE_HALT) cycle_q <= cycle_q + 64'd1;
            if (pc_en) instret_q <= instret_q + 64'd1;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: randomized self-checking bench; each instruction's expected
// stage trace is built from its opcode and planned memory delays.
module tb_stage_sequencer;

    localparam int T = 16;

    localparam logic [2:0] S_F = 3'd0;
    localparam logic [2:0] S_D = 3'd1;
    localparam logic [2:0] S_E = 3'd2;
    localparam logic [2:0] S_M = 3'd3;
    localparam logic [2:0] S_R = 3'd4;
    localparam logic [2:0] S_H = 3'd7;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [6:0]  opcode = OP_IMM;
    logic [11:0] funct12 = 12'h000;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic [2:0]  stage;
    logic        imem_req, dmem_req, ir_en, pc_en, rd_we, halted, bus_error;
`ifdef STAGE_SEQ_PERF_EN
    logic [63:0] cycle_cnt, instret_cnt;
    logic [63:0] exp_cyc = 64'd0;
    logic [63:0] exp_ret = 64'd0;
`endif

    int   checks = 0;
    int   errors = 0;
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    stage_sequencer #(.MEM_TIMEOUT(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .funct12   (funct12),
        .imem_ack  (imem_ack),
        .dmem_ack  (dmem_ack),
        .halt_req  (halt_req),
        .resume    (resume),
        .stage     (stage),
        .imem_req  (imem_req),
        .dmem_req  (dmem_req),
        .ir_en     (ir_en),
        .pc_en     (pc_en),
        .rd_we     (rd_we),
        .halted    (halted),
        .bus_error (bus_error)
`ifdef STAGE_SEQ_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, compare at the falling edge.
    task automatic step(input logic [2:0] st, input logic ia, input logic da,
                        input logic hr, input logic rs);
        logic wr;
        imem_ack = ia;
        dmem_ack = da;
        halt_req = hr;
        resume   = rs;
        wr = (opcode != OP_ST) && (opcode != OP_BR);
        @(negedge clk);
        check("stage",     64'(stage),     64'(st));
        check("imem_req",  64'(imem_req),  64'(st == S_F));
        check("ir_en",     64'(ir_en),     64'(st == S_F && ia));
        check("dmem_req",  64'(dmem_req),  64'(st == S_M));
        check("pc_en",     64'(pc_en),     64'(st == S_R));
        check("rd_we",     64'(rd_we),     64'(st == S_R && wr));
        check("halted",    64'(halted),    64'(st == S_H));
        check("bus_error", 64'(bus_error), 64'(exp_err));
`ifdef STAGE_SEQ_PERF_EN
        check("cycle_cnt",   cycle_cnt,   exp_cyc);
        check("instret_cnt", instret_cnt, exp_ret);
        if (st != S_H) exp_cyc = exp_cyc + 64'd1;
        if (st == S_R) exp_ret = exp_ret + 64'd1;
`endif
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset: outputs must change with no clock edge.
    task automatic do_reset();
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        halt_req = 1'b0;
        resume   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_err = 1'b0;
        check("rst_stage",    64'(stage),     64'(S_F));
        check("rst_imem_req", 64'(imem_req),  64'(1'b1));
        check("rst_dmem_req", 64'(dmem_req),  64'(1'b0));
        check("rst_pc_en",    64'(pc_en),     64'(1'b0));
        check("rst_rd_we",    64'(rd_we),     64'(1'b0));
        check("rst_halted",   64'(halted),    64'(1'b0));
        check("rst_bus_err",  64'(bus_error), 64'(1'b0));
`ifdef STAGE_SEQ_PERF_EN
        exp_cyc = 64'd0;
        exp_ret = 64'd0;
        check("rst_cycle_cnt", cycle_cnt, 64'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Plays one instruction: di/dd are the stalled cycles before imem/dmem ack
    // (>= T means never acked). hr is held for the whole instruction.
    task automatic instr(input logic [6:0] op, input logic [11:0] f12, input int di,
                         input int dd, input logic hr, output logic h);
        opcode  = op;
        funct12 = f12;
        h = 1'b1;
        for (int k = 0; k <= di && k < T; k++) step(S_F, k == di, 1'b0, hr, 1'b0);
        if (di >= T) begin
            exp_err = 1'b1;
            return;
        end
        step(S_D, 1'b0, 1'b0, hr, 1'b0);
        step(S_E, 1'b0, 1'b0, hr, 1'b0);
        if (op == OP_SYS && f12 == 12'h001) return;
        if (op == OP_LD || op == OP_ST) begin
            for (int k = 0; k <= dd && k < T; k++) step(S_M, 1'b0, k == dd, hr, 1'b0);
            if (dd >= T) begin
                exp_err = 1'b1;
                return;
            end
        end
        step(S_R, 1'b0, 1'b0, hr, 1'b0);
        h = hr;
    endtask

    task automatic leave_halt(input logic hr, input int idle);
        for (int k = 0; k < idle; k++) step(S_H, 1'b0, 1'b0, hr, 1'b0);
        step(S_H, 1'b0, 1'b0, hr, 1'b1);
    endtask

    function automatic int pick_delay();
        int r;
        r = int'($urandom_range(0, 19));
        return (r == 0) ? T : (r == 1) ? T - 1 : int'($urandom_range(0, 3));
    endfunction

    initial begin
        logic       h;
        logic [6:0] ops [6];
        ops = '{OP_IMM, OP_REG, OP_LD, OP_ST, OP_BR, OP_SYS};

        do_reset();
        instr(OP_IMM, 12'h000, 0, 0, 1'b0, h);
        instr(OP_LD,  12'h000, 0, 3, 1'b0, h);
        instr(OP_ST,  12'h000, 1, 0, 1'b0, h);
        instr(OP_BR,  12'h000, 0, 0, 1'b0, h);
        instr(OP_SYS, 12'h001, 0, 0, 1'b0, h);
        leave_halt(1'b0, 2);
        instr(OP_SYS, 12'h000, 0, 0, 1'b0, h);

        instr(OP_IMM, 12'h000, T, 0, 1'b0, h);
        leave_halt(1'b0, 1);
        do_reset();
        instr(OP_IMM, 12'h000, T - 1, 0, 1'b0, h);
        instr(OP_LD,  12'h000, 0, T - 1, 1'b0, h);
        instr(OP_ST,  12'h000, 0, T, 1'b0, h);
        leave_halt(1'b1, 1);
        do_reset();

        opcode = OP_LD;
        step(S_F, 1'b1, 1'b0, 1'b0, 1'b0);
        step(S_D, 1'b0, 1'b0, 1'b0, 1'b0);
        step(S_E, 1'b0, 1'b0, 1'b0, 1'b0);
        step(S_M, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check("mem_dmem_req", 64'(dmem_req), 64'(1'b1));
        do_reset();

        instr(OP_IMM, 12'h000, 0, 0, 1'b1, h);
        leave_halt(1'b1, 1);
        instr(OP_REG, 12'h000, 1, 0, 1'b1, h);
        leave_halt(1'b0, 0);
        instr(OP_IMM, 12'h000, 0, 0, 1'b0, h);

        for (int n = 0; n < 80; n++) begin
            logic [6:0]  op;
            logic [11:0] f12;
            op  = ops[$urandom_range(0, 5)];
            f12 = ($urandom_range(0, 1) == 1) ? 12'h001 : 12'h000;
            instr(op, f12, pick_delay(), pick_delay(), $urandom_range(0, 7) == 0, h);
            if (h) leave_halt($urandom_range(0, 1) == 1, int'($urandom_range(0, 2)));
            if ($urandom_range(0, 29) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
